// File: rtl/hazard_unit_if.sv
// ---------------------------------------------------------------------------
// | Module   : hazard_unit_if                                               |
// | Brief    : Pipeline-side signal bundle for the hazard/forwarding unit   |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
`default_nettype none

interface hazard_unit_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_branch;
  logic [4:0]  ex_rw;
  logic        ex_reg_write;
  logic        ex_memtoreg;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  mem_rw;
  logic        mem_reg_write;
  logic [4:0]  wb_rw;
  logic        wb_reg_write;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        wrn;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
           ex_rw, ex_reg_write, ex_memtoreg, ex_rs, ex_rt,
           mem_rw, mem_reg_write, wb_rw, wb_reg_write,
    input  pc_write, if_id_write, if_id_flush, wrn, fwd_a, fwd_b, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
           ex_rw, ex_reg_write, ex_memtoreg, ex_rs, ex_rt,
           mem_rw, mem_reg_write, wb_rw, wb_reg_write,
    output pc_write, if_id_write, if_id_flush, wrn, fwd_a, fwd_b, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// | Module   : hazard_unit                                                  |
// | Brief    : RAW hazard stall sequencer and EX-stage forwarding selects   |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_unit #(
  parameter int FWD_EN     = 1,
  parameter int LOAD_STALL = 1
) (
  input  logic         clock,
  input  logic         reset,
  hazard_unit_if.slave bus
);

  localparam logic [1:0] c_load_extra = 2'(LOAD_STALL - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_next;
  logic [15:0] r_stall_cycles;
  logic        w_stall;
  logic        w_ex_hit;
  logic        w_mem_hit;
  logic        w_hazard;
  logic [1:0]  w_extra;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;

  // Register $0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic use_src, input logic [4:0] src,
                                     input logic [4:0] dst, input logic wr);
    return use_src && (src == dst) && (dst != 5'd0) && wr;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (bus.mem_reg_write && (bus.mem_rw != 5'd0) && (bus.mem_rw == src))
      sel = 2'b01;
    else if (bus.wb_reg_write && (bus.wb_rw != 5'd0) && (bus.wb_rw == src))
      sel = 2'b10;
    return sel;
  endfunction

  assign w_ex_hit  = reg_match(bus.id_use_rs, bus.id_rs, bus.ex_rw, bus.ex_reg_write)
                   | reg_match(bus.id_use_rt, bus.id_rt, bus.ex_rw, bus.ex_reg_write);
  assign w_mem_hit = reg_match(bus.id_use_rs, bus.id_rs, bus.mem_rw, bus.mem_reg_write)
                   | reg_match(bus.id_use_rt, bus.id_rt, bus.mem_rw, bus.mem_reg_write);

  // Without forwarding an EX producer needs two bubbles, a MEM producer one.
  assign w_hazard = (FWD_EN != 0) ? (w_ex_hit & bus.ex_memtoreg) : (w_ex_hit | w_mem_hit);
  assign w_extra  = (FWD_EN != 0) ? c_load_extra : {1'b0, w_ex_hit};

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hazard) begin
          w_stall = 1'b1;
          if (w_extra != 2'd0) begin
            w_state_next = ST_STALL;
            w_cnt_next   = w_extra - 2'd1;
          end
        end
      end
      ST_STALL: begin
        w_stall = 1'b1;
        if (r_cnt == 2'd0)
          w_state_next = ST_IDLE;
        else
          w_cnt_next = r_cnt - 2'd1;
      end
      default: w_state_next = ST_IDLE;
    endcase
    // Outputs take their reset values while reset is held, not only after it.
    if (reset)
      w_stall = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 2'd0;
      r_stall_cycles <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_stall && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if ((FWD_EN != 0) && !reset) begin
      w_fwd_a = fwd_sel(bus.ex_rs);
      w_fwd_b = fwd_sel(bus.ex_rt);
    end
  end

  assign bus.pc_write     = !w_stall;
  assign bus.if_id_write  = !w_stall;
  assign bus.wrn          = !w_stall;
  assign bus.if_id_flush  = bus.id_branch && !w_stall && !reset;
  assign bus.fwd_a        = w_fwd_a;
  assign bus.fwd_b        = w_fwd_b;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// | Module   : tb_hazard_unit                                               |
// | Brief    : Directed checks on three hazard_unit configurations          |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [4:0] id_rs, id_rt, ex_rw, ex_rs, ex_rt, mem_rw, wb_rw;
  logic       id_use_rs, id_use_rt, id_branch, ex_reg_write, ex_memtoreg;
  logic       mem_reg_write, wb_reg_write;

  // Index 0: FWD_EN=1/LOAD_STALL=1, 1: FWD_EN=1/LOAD_STALL=3, 2: FWD_EN=0.
  hazard_unit_if bus [3] ();
  logic [2:0]  ctl [3];
  logic        flush [3];
  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic [15:0] sc [3];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_bus
      assign bus[g].id_rs         = id_rs;
      assign bus[g].id_rt         = id_rt;
      assign bus[g].id_use_rs     = id_use_rs;
      assign bus[g].id_use_rt     = id_use_rt;
      assign bus[g].id_branch     = id_branch;
      assign bus[g].ex_rw         = ex_rw;
      assign bus[g].ex_reg_write  = ex_reg_write;
      assign bus[g].ex_memtoreg   = ex_memtoreg;
      assign bus[g].ex_rs         = ex_rs;
      assign bus[g].ex_rt         = ex_rt;
      assign bus[g].mem_rw        = mem_rw;
      assign bus[g].mem_reg_write = mem_reg_write;
      assign bus[g].wb_rw         = wb_rw;
      assign bus[g].wb_reg_write  = wb_reg_write;
      assign ctl[g]   = {bus[g].pc_write, bus[g].if_id_write, bus[g].wrn};
      assign flush[g] = bus[g].if_id_flush;
      assign fa[g]    = bus[g].fwd_a;
      assign fb[g]    = bus[g].fwd_b;
      assign sc[g]    = bus[g].stall_cycles;
    end
  endgenerate

  hazard_unit #(.FWD_EN(1), .LOAD_STALL(1)) u_dut_a (.clock(clock), .reset(reset), .bus(bus[0]));
  hazard_unit #(.FWD_EN(1), .LOAD_STALL(3)) u_dut_b (.clock(clock), .reset(reset), .bus(bus[1]));
  hazard_unit #(.FWD_EN(0), .LOAD_STALL(1)) u_dut_c (.clock(clock), .reset(reset), .bus(bus[2]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic clear_in();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_branch = 1'b0;
    ex_rw = 5'd0; ex_reg_write = 1'b0; ex_memtoreg = 1'b0; ex_rs = 5'd0; ex_rt = 5'd0;
    mem_rw = 5'd0; mem_reg_write = 1'b0; wb_rw = 5'd0; wb_reg_write = 1'b0;
  endtask

  // lw $8 in EX, ID reads $8 through rs.
  task automatic load_use();
    ex_rw = 5'd8; ex_reg_write = 1'b1; ex_memtoreg = 1'b1;
    id_rs = 5'd8; id_use_rs = 1'b1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_in();
    #3;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_state_%0d", i), {8'd0, ctl[i], flush[i], fa[i], fb[i], sc[i]},
            {8'd0, 3'b111, 1'b0, 2'b00, 2'b00, 16'h0000});
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Load-use: 1 bubble (a), 3 bubbles (b), EX RAW without forwarding: 2 bubbles (c)
    load_use();
    @(negedge clock);
    check("lu_c1_a", ctl[0], 3'b000);
    check("lu_c1_b", ctl[1], 3'b000);
    check("lu_c1_c", ctl[2], 3'b000);
    tick(); clear_in();
    @(negedge clock);
    check("lu_c2_a", ctl[0], 3'b111);
    check("lu_cnt_a", sc[0], 16'd1);
    check("lu_c2_b", ctl[1], 3'b000);
    check("lu_c2_c", ctl[2], 3'b000);
    tick();
    @(negedge clock);
    check("lu_c3_b", ctl[1], 3'b000);
    check("lu_c3_c", ctl[2], 3'b111);
    check("lu_cnt_c", sc[2], 16'd2);
    tick();
    @(negedge clock);
    check("lu_c4_b", ctl[1], 3'b111);
    check("lu_cnt_b", sc[1], 16'd3);

    // MEM producer without forwarding: one bubble
    tick(); clear_in();
    mem_rw = 5'd9; mem_reg_write = 1'b1; id_rt = 5'd9; id_use_rt = 1'b1;
    @(negedge clock);
    check("mem_raw_c", ctl[2], 3'b000);
    check("mem_raw_a", ctl[0], 3'b111);
    tick(); clear_in();
    @(negedge clock);
    check("mem_raw_done_c", ctl[2], 3'b111);
    check("mem_raw_cnt_c", sc[2], 16'd3);
    mem_rw = 5'd9; mem_reg_write = 1'b1; id_rt = 5'd9; id_use_rt = 1'b0;
    #1 check("no_use_rt_c", ctl[2], 3'b111);
    clear_in();
    ex_rw = 5'd0; ex_reg_write = 1'b1; ex_memtoreg = 1'b1; id_rs = 5'd0; id_use_rs = 1'b1;
    #1 check("zero_reg_a", ctl[0], 3'b111);
    check("zero_reg_c", ctl[2], 3'b111);

    // Forwarding selects
    clear_in();
    mem_rw = 5'd5; mem_reg_write = 1'b1; wb_rw = 5'd5; wb_reg_write = 1'b1; ex_rs = 5'd5;
    #1 check("fwd_mem_a", fa[0], 2'b01);
    check("fwd_off_c", fa[2], 2'b00);
    mem_reg_write = 1'b0;
    #1 check("fwd_wb_a", fa[0], 2'b10);
    mem_reg_write = 1'b1; mem_rw = 5'd0; wb_rw = 5'd0;
    #1 check("fwd_zero_a", fa[0], 2'b00);
    check("fwd_zero_ctl", ctl[0], 3'b111);
    mem_rw = 5'd5; wb_rw = 5'd7; ex_rt = 5'd7;
    #1 check("fwd_pair_a", {fa[0], fb[0]}, 4'b0110);
    ex_rt = 5'd5;
    #1 check("fwd_prio_b", fb[0], 2'b01);

    // Branch during load-use stall: stall wins, flush follows next cycle
    tick(); clear_in();
    load_use(); id_branch = 1'b1;
    @(negedge clock);
    check("br_stalled_a", flush[0], 1'b0);
    tick(); clear_in(); id_branch = 1'b1;
    @(negedge clock);
    check("br_flush_a", flush[0], 1'b1);
    check("br_stalled_b", flush[1], 1'b0);
    tick(); clear_in();
    tick();
    tick();

    // Reset in the second cycle of a 3-cycle stall
    load_use();
    @(negedge clock);
    check("rst_c1_b", ctl[1], 3'b000);
    tick(); clear_in();
    @(negedge clock);
    check("rst_c2_b", ctl[1], 3'b000);
    #1 reset = 1'b1;
    #1 check("rst_async_b", {8'd0, ctl[1], flush[1], fa[1], fb[1], sc[1]},
             {8'd0, 3'b111, 1'b0, 2'b00, 2'b00, 16'h0000});
    load_use();
    #1 check("rst_gate_a", ctl[0], 3'b111);
    clear_in();
    reset = 1'b0;
    @(negedge clock);
    check("rst_idle_b", ctl[1], 3'b111);

    // Continuous stall: counter saturates without wrapping
    tick();
    load_use();
    repeat (65534) tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("sat_pre_%0d", i), sc[i], 16'hFFFE);
    repeat (6000) tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("sat_hold_%0d", i), sc[i], 16'hFFFF);
    check("sat_ctl_a", ctl[0], 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
